// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic             ext_sel_o,
    output logic [2:0]       alu_op_o,
    output logic             funct_sel_o,
    output logic [1:0]       pc_source_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state;
    logic   illegal_q;
    logic   retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            MEM_WB, R_WB, BRANCH, JUMP, I_WB: retire = 1'b1;
            MEM_WR:                           retire = mem_ready_i;
            default:                          retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= FETCH;
            illegal_q   <= 1'b0;
            instr_cnt_o <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (retire)
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            case (state)
                FETCH:
                    if (mem_ready_i)
                        state <= DECODE;
                DECODE:
                    case (opcode_i)
                        OP_R:                     state <= R_EXEC;
                        OP_LW, OP_SW:             state <= MEM_ADDR;
                        OP_BEQ, OP_BNE:           state <= BRANCH;
                        OP_J:                     state <= JUMP;
                        OP_ADDI, OP_SLTI, OP_ORI: state <= I_EXEC;
                        default: begin
                            state     <= FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                MEM_ADDR:
                    state <= (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:
                    if (mem_ready_i)
                        state <= MEM_WB;
                MEM_WR:
                    if (mem_ready_i)
                        state <= FETCH;
                R_EXEC:  state <= R_WB;
                I_EXEC:  state <= I_WB;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs decode straight from the state; reset masks every strobe.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_dst_o    = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        ext_sel_o    = 1'b0;
        alu_op_o     = 3'b000;
        funct_sel_o  = 1'b0;
        pc_source_o  = 2'd0;
        if (!rst_i) begin
            case (state)
                FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'd1;
                    alu_op_o    = ALU_ADD;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                DECODE: begin
                    alu_src_b_o = 2'd3;
                    alu_op_o    = ALU_ADD;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = ALU_ADD;
                end
                MEM_RD: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                MEM_WR: begin
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_ADD;
                    funct_sel_o = 1'b1;
                end
                R_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_SUB;
                    pc_source_o = 2'd1;
                    pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                end
                JUMP: begin
                    pc_source_o = 2'd2;
                    pc_write_o  = 1'b1;
                end
                I_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    ext_sel_o   = (opcode_i == OP_ORI);
                    case (opcode_i)
                        OP_SLTI: alu_op_o = ALU_SLT;
                        OP_ORI:  alu_op_o = ALU_OR;
                        default: alu_op_o = ALU_ADD;
                    endcase
                end
                I_WB: begin
                    reg_write_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal_o = illegal_q;
    assign state_o   = state;

endmodule
